// File: rtl/pc_gen.sv
// Program-counter generator: trap > redirect > return > stall > sequential.
// Optional return-address stack is compiled in when PC_RAS_EN is defined.
module pc_gen #(
    parameter int          XLEN       = 32,
    parameter logic [63:0] INITIAL_PC = 64'h0000_0000_8000_0000,
    parameter int          C_EXT      = 0,
    parameter int          RAS_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            is_compressed,
    input  logic            call_push,
    input  logic            ret_pop,
    output logic [XLEN-1:0] out_addr,
    output logic            misaligned,
    output logic            ras_empty
);

    localparam logic [XLEN-1:0] RESET_PC   = INITIAL_PC[XLEN-1:0];
    localparam logic [XLEN-1:0] ALIGN_MASK = (C_EXT != 0) ? XLEN'(1) : XLEN'(3);

    logic [XLEN-1:0] step;
    logic [XLEN-1:0] seq_addr;
    logic            redirect_bad;
    logic            pop_sel;
    logic [XLEN-1:0] ras_top_data;

    assign step         = ((C_EXT != 0) && is_compressed) ? XLEN'(2) : XLEN'(4);
    assign seq_addr     = out_addr + step;
    assign redirect_bad = |(redirect_addr & ALIGN_MASK);

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_addr   <= RESET_PC;
            misaligned <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            if (trap_valid) begin
                out_addr <= trap_vector & ~ALIGN_MASK;
            end else if (redirect_valid) begin
                // a rejected target holds the PC; the request is consumed either way
                if (redirect_bad) begin
                    misaligned <= 1'b1;
                end else begin
                    out_addr <= redirect_addr;
                end
            end else if (pop_sel) begin
                out_addr <= ras_top_data;
            end else if (!stall) begin
                out_addr <= seq_addr;
            end
        end
    end

`ifdef PC_RAS_EN
    localparam int          PW       = $clog2(RAS_DEPTH);
    localparam logic [PW:0] RAS_FULL = (PW + 1)'(RAS_DEPTH);

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_top;
    logic [PW-1:0]   ras_wr_idx;
    logic [PW:0]     ras_cnt;
    logic            push_en;

    assign push_en      = call_push && !stall && !trap_valid;
    assign pop_sel      = ret_pop && !trap_valid && !redirect_valid && (ras_cnt != '0);
    assign ras_top_data = ras_mem[ras_top];
    assign ras_empty    = (ras_cnt == '0);
    assign ras_wr_idx   = pop_sel ? ras_top : ras_top + 1'b1;

    // pointer wraps naturally, so a push into a full stack overwrites the oldest entry
    always_ff @(posedge clk) begin
        if (!reset) begin
            ras_top <= '0;
            ras_cnt <= '0;
        end else if (push_en && !pop_sel) begin
            ras_top <= ras_top + 1'b1;
            if (ras_cnt != RAS_FULL) begin
                ras_cnt <= ras_cnt + 1'b1;
            end
        end else if (pop_sel && !push_en) begin
            ras_top <= ras_top - 1'b1;
            ras_cnt <= ras_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push_en) begin
            ras_mem[ras_wr_idx] <= seq_addr;
        end
    end
`else
    logic unused_ras;

    assign unused_ras   = call_push ^ ret_pop;
    assign pop_sel      = 1'b0;
    assign ras_top_data = '0;
    assign ras_empty    = 1'b1;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (C_EXT=0 and C_EXT=1) against a list-based model.
module tb_pc_gen;

    localparam logic [31:0] INIT  = 32'h8000_0000;
    localparam int          DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_vector = '0;
    logic        is_compressed = 1'b0;
    logic        call_push = 1'b0;
    logic        ret_pop = 1'b0;
    logic [31:0] out0, out1;
    logic        mis0, mis1, emp0, emp1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pc_gen #(.C_EXT(0)) dut0 (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .is_compressed(is_compressed), .call_push(call_push), .ret_pop(ret_pop),
        .out_addr(out0), .misaligned(mis0), .ras_empty(emp0)
    );

    pc_gen #(.C_EXT(1)) dut1 (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .is_compressed(is_compressed), .call_push(call_push), .ret_pop(ret_pop),
        .out_addr(out1), .misaligned(mis1), .ras_empty(emp1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: stack kept as a list, oldest entry at index 0.
    logic [31:0] m_pc  [2];
    logic        m_mis [2];
    int          m_cnt [2];
    logic [31:0] m_stk [2][DEPTH];

    task automatic model_step(input int k);
        logic [31:0] amask, seq, tgt;
        bit push, pop;
        amask    = (k == 1) ? 32'h1 : 32'h3;
        seq      = m_pc[k] + (((k == 1) && is_compressed) ? 32'd2 : 32'd4);
        m_mis[k] = 1'b0;
        if (!reset) begin
            m_pc[k]  = INIT;
            m_cnt[k] = 0;
        end else begin
            push = RAS_ON && call_push && !stall && !trap_valid;
            pop  = RAS_ON && ret_pop && !trap_valid && !redirect_valid && (m_cnt[k] > 0);
            tgt  = pop ? m_stk[k][m_cnt[k]-1] : 32'h0;
            if (trap_valid) m_pc[k] = trap_vector & ~amask;
            else if (redirect_valid) begin
                if ((redirect_addr & amask) != 0) m_mis[k] = 1'b1;
                else m_pc[k] = redirect_addr;
            end
            else if (pop) m_pc[k] = tgt;
            else if (!stall) m_pc[k] = seq;

            if (push && pop) m_stk[k][m_cnt[k]-1] = seq;
            else if (pop) m_cnt[k]--;
            else if (push) begin
                if (m_cnt[k] == DEPTH) begin
                    for (int j = 0; j < DEPTH - 1; j++) m_stk[k][j] = m_stk[k][j+1];
                    m_cnt[k]--;
                end
                m_stk[k][m_cnt[k]] = seq;
                m_cnt[k]++;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc_c0",    out0, m_pc[0]);
            check("mis_c0",   {31'b0, mis0}, {31'b0, m_mis[0]});
            check("empty_c0", {31'b0, emp0}, {31'b0, (!RAS_ON) || (m_cnt[0] == 0)});
            check("pc_c1",    out1, m_pc[1]);
            check("mis_c1",   {31'b0, mis1}, {31'b0, m_mis[1]});
            check("empty_c1", {31'b0, emp1}, {31'b0, (!RAS_ON) || (m_cnt[1] == 0)});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; redirect_valid = 0; trap_valid = 0;
        is_compressed = 0; call_push = 0; ret_pop = 0;
    endtask

    initial begin
        cyc();
        chk_en = 1'b1;
        cyc();
        reset = 1'b1;
        check("reset_pc", out0, 32'h8000_0000);
        check("reset_empty", {31'b0, emp0}, 32'h1);
        check("reset_mis", {31'b0, mis0}, 32'h0);

        // free-running sequence
        cyc(); check("seq1", out0, 32'h8000_0004);
        cyc(); check("seq2", out0, 32'h8000_0008);
        cyc(); check("seq3", out0, 32'h8000_000C);

        // redirect wins over stall; misaligned target rejected on C_EXT=0 only
        stall = 1; redirect_valid = 1; redirect_addr = 32'h8000_0100;
        cyc(); check("redir_stall", out0, 32'h8000_0100);
        stall = 0; redirect_addr = 32'h8000_0102;
        cyc();
        check("misal_hold", out0, 32'h8000_0100);
        check("misal_flag", {31'b0, mis0}, 32'h1);
        check("c1_half_ok", out1, 32'h8000_0102);
        check("c1_no_flag", {31'b0, mis1}, 32'h0);
        redirect_valid = 0;
        cyc();
        check("misal_pulse", {31'b0, mis0}, 32'h0);
        check("after_misal", out0, 32'h8000_0104);

        // trap beats redirect, vector aligned down
        trap_valid = 1; trap_vector = 32'h0000_0203;
        redirect_valid = 1; redirect_addr = 32'h0000_0400;
        cyc();
        check("trap_c0", out0, 32'h0000_0200);
        check("trap_c1", out1, 32'h0000_0202);
        check("trap_nomis", {31'b0, mis0}, 32'h0);
        idle();

        stall = 1;
        cyc(); cyc();
        check("stall_hold", out0, 32'h0000_0200);
        stall = 0;

        // wrap with compressed step
        redirect_valid = 1; redirect_addr = 32'hFFFF_FFFE;
        cyc(); check("c1_at_top", out1, 32'hFFFF_FFFE);
        redirect_valid = 0; is_compressed = 1;
        cyc();
        check("c1_wrap", out1, 32'h0000_0000);
        check("c0_ignores_c", out0, 32'h0000_0204);
        is_compressed = 0;
        redirect_valid = 1; redirect_addr = 32'hFFFF_FFFC;
        cyc(); redirect_valid = 0;
        cyc(); check("c0_wrap", out0, 32'h0000_0000);

        // reset overrides stall and redirect
        stall = 1; redirect_valid = 1; redirect_addr = 32'h0000_0300; reset = 0;
        cyc(); check("reset_override", out0, INIT);
        reset = 1; idle();

`ifdef PC_RAS_EN
        redirect_valid = 1; redirect_addr = 32'h10;
        cyc();
        for (int a = 1; a <= 5; a++) begin
            call_push = 1; redirect_valid = 1; redirect_addr = (a + 1) * 16;
            cyc();
        end
        idle();
        ret_pop = 1;
        cyc(); check("pop1", out0, 32'h54);
        cyc(); check("pop2", out0, 32'h44);
        cyc(); check("pop3", out0, 32'h34);
        cyc(); check("pop4", out0, 32'h24);
        check("pop4_empty", {31'b0, emp0}, 32'h1);
        cyc(); check("pop5_ignored", out0, 32'h28);
        ret_pop = 0;

        call_push = 1;
        cyc(); check("push_one", out0, 32'h2C);
        ret_pop = 1;
        cyc();
        check("pushpop_pc", out0, 32'h2C);
        check("pushpop_cnt", {31'b0, emp0}, 32'h0);
        call_push = 0;
        cyc();
        check("pushpop_new", out0, 32'h30);
        check("pushpop_empty", {31'b0, emp0}, 32'h1);
        idle();

        call_push = 1; trap_valid = 1; trap_vector = 32'h500;
        cyc();
        check("trap_pc", out0, 32'h500);
        check("trap_nopush", {31'b0, emp0}, 32'h1);
        trap_valid = 0;
        cyc();
        ret_pop = 1; reset = 0;
        cyc();
        check("rst_pushpop_pc", out0, INIT);
        check("rst_pushpop_empty", {31'b0, emp0}, 32'h1);
        reset = 1; idle();
`else
        call_push = 1; ret_pop = 1;
        cyc(); cyc();
        check("noras_empty", {31'b0, emp0}, 32'h1);
        check("noras_seq", out0, INIT + 32'd8);
        idle();
`endif

        // mixed sweep, checked every cycle by the model
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 59) != 0);
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 5) == 0);
            redirect_addr  = $urandom & 32'h0000_0FFF;
            trap_valid     = ($urandom_range(0, 19) == 0);
            trap_vector    = $urandom;
            is_compressed  = $urandom_range(0, 1) != 0;
            call_push      = ($urandom_range(0, 3) == 0);
            ret_pop        = ($urandom_range(0, 3) == 0);
            cyc();
        end
        reset = 1; idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
